// File: rtl/wide_add_pkg.sv
// Shared types and default geometry for the word-serial wide adder.
// Optional subtract mode is enabled with WIDE_ADD_SUB_EN.
package wide_add_pkg;

   localparam int WORD_W_DEF    = 16;
   localparam int NUM_WORDS_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/wide_add_sequencer_add_slice.sv
// One WORD_W-bit adder slice with carry in/out; purely combinational.
// Kept separate so a faster slice can replace it without touching the sequencer FSM.
module add_slice #(
   parameter int WORD_W = 16
) (
   input  logic [WORD_W-1:0] x,
   input  logic [WORD_W-1:0] y,
   input  logic              cin,
   output logic [WORD_W-1:0] s,
   output logic              cout
);

   logic [WORD_W:0] full;

   always_comb begin
      full = {1'b0, x} + {1'b0, y} + {{WORD_W{1'b0}}, cin};
      s    = full[WORD_W-1:0];
      cout = full[WORD_W];
   end

endmodule

// File: rtl/wide_add_sequencer.sv
// Word-serial NUM_WORDS*WORD_W-bit adder: LS word first in, LS word first out, 1-cycle latency.
// Backpressure: in_ready drops while a sum word is stalled; WIDE_ADD_SUB_EN adds a sub port (A-B).
module wide_add_sequencer
   import wide_add_pkg::*;
#(
   parameter  int WORD_W    = WORD_W_DEF,
   parameter  int NUM_WORDS = NUM_WORDS_DEF,
   localparam int CNT_W     = $clog2(NUM_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
`ifdef WIDE_ADD_SUB_EN
   input  logic              sub,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] a_word,
   input  logic [WORD_W-1:0] b_word,
   output logic [WORD_W-1:0] sum_word,
   output logic              sum_valid,
   input  logic              sum_ready,
   output logic              sum_last,
   output logic              cout,
   output logic              busy,
   output logic              done
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  counter_q, counter_d;
   logic              carry_q, carry_d;
   logic [WORD_W-1:0] sum_word_q, sum_word_d;
   logic              sum_valid_q, sum_valid_d;
   logic              sum_last_q, sum_last_d;
   logic              cout_q, cout_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [WORD_W-1:0] b_eff;
   logic              carry_init;
   logic [WORD_W-1:0] slice_s;
   logic              slice_c;
   logic              in_hs;
   logic              out_hs;

`ifdef WIDE_ADD_SUB_EN
   // Subtract is A + ~B + 1; the +1 comes in through the initial carry.
   logic sub_q, sub_d;
   assign b_eff      = sub_q ? ~b_word : b_word;
   assign carry_init = sub;
`else
   assign b_eff      = b_word;
   assign carry_init = 1'b0;
`endif

   add_slice #(.WORD_W(WORD_W)) u_add_slice (
      .x   (a_word),
      .y   (b_eff),
      .cin (carry_q),
      .s   (slice_s),
      .cout(slice_c)
   );

   always_comb begin
      state_d     = state_q;
      counter_d   = counter_q;
      carry_d     = carry_q;
      sum_word_d  = sum_word_q;
      sum_valid_d = sum_valid_q;
      sum_last_d  = sum_last_q;
      cout_d      = cout_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      in_ready    = 1'b0;
      in_hs       = 1'b0;
      out_hs      = sum_valid_q && sum_ready;
`ifdef WIDE_ADD_SUB_EN
      sub_d       = sub_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               carry_d   = carry_init;
               counter_d = '0;
               cout_d    = 1'b0;
               busy_d    = 1'b1;
`ifdef WIDE_ADD_SUB_EN
               sub_d     = sub;
`endif
            end
         end
         RUN: begin
            in_ready = !sum_valid_q || sum_ready;
            in_hs    = in_valid && in_ready;
            if (out_hs) begin
               sum_valid_d = 1'b0;
            end
            // A new word overrides the drain so full throughput keeps sum_valid high.
            if (in_hs) begin
               sum_word_d  = slice_s;
               carry_d     = slice_c;
               sum_valid_d = 1'b1;
               counter_d   = counter_q + CNT_W'(1);
               if (counter_q == LAST_IDX) begin
                  sum_last_d = 1'b1;
                  cout_d     = slice_c;
                  state_d    = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (out_hs) begin
               sum_valid_d = 1'b0;
               sum_last_d  = 1'b0;
               done_d      = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         counter_q   <= '0;
         carry_q     <= 1'b0;
         sum_word_q  <= '0;
         sum_valid_q <= 1'b0;
         sum_last_q  <= 1'b0;
         cout_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
         sub_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         carry_q     <= carry_d;
         sum_word_q  <= sum_word_d;
         sum_valid_q <= sum_valid_d;
         sum_last_q  <= sum_last_d;
         cout_q      <= cout_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef WIDE_ADD_SUB_EN
         sub_q       <= sub_d;
`endif
      end
   end

   assign sum_word  = sum_word_q;
   assign sum_valid = sum_valid_q;
   assign sum_last  = sum_last_q;
   assign cout      = cout_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer: vector table plus reset, stall and ignored-input sequences.
module tb_wide_add_sequencer;

   localparam int W = 16;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
`ifdef WIDE_ADD_SUB_EN
   logic         sub;
`endif
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_word;
   logic [W-1:0] b_word;
   logic [W-1:0] sum_word;
   logic         sum_valid;
   logic         sum_ready;
   logic         sum_last;
   logic         cout;
   logic         busy;
   logic         done;

   always #5 clk = ~clk;

   wide_add_sequencer #(.WORD_W(W), .NUM_WORDS(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
`ifdef WIDE_ADD_SUB_EN
      .sub      (sub),
`endif
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_word   (a_word),
      .b_word   (b_word),
      .sum_word (sum_word),
      .sum_valid(sum_valid),
      .sum_ready(sum_ready),
      .sum_last (sum_last),
      .cout     (cout),
      .busy     (busy),
      .done     (done)
   );

   typedef struct packed {
      logic [N*W-1:0] a;
      logic [N*W-1:0] b;
      logic [N*W-1:0] s;
      logic           c;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                               input logic [N*W-1:0] s, input logic c);
      vec_t v;
      v.a = a; v.b = b; v.s = s; v.c = c;
      return v;
   endfunction

   // Streams one operation; returns cycles from the first RUN cycle to the last output handshake.
   task automatic run_op(input vec_t v, input int stall_len, input bit poke_start,
                         input bit sub_op, output int cycles);
      int ai, oi, cyc, stall;
      bit ihs, ohs;
      @(negedge clk);
      start = 1'b1;
`ifdef WIDE_ADD_SUB_EN
      sub = sub_op;
`else
      if (sub_op) $display("note: subtract requested without sub support");
`endif
      @(negedge clk);
      start = 1'b0;
      ai = 0; oi = 0; cyc = 0; stall = stall_len;
      while (oi < N && cyc < 200) begin
         in_valid  = (ai < N);
         a_word    = (ai < N) ? v.a[ai*W +: W] : '0;
         b_word    = (ai < N) ? v.b[ai*W +: W] : '0;
         start     = poke_start && (cyc == 3);
         sum_ready = !(oi == 2 && sum_valid && stall > 0);
         #1;
         if (cyc == 0) chk("busy_after_start", {31'd0, busy}, 32'd1);
         if (!sum_ready) begin
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_sum_word", {16'd0, sum_word}, {16'd0, v.s[2*W +: W]});
            stall--;
         end
         ihs = in_valid && in_ready;
         ohs = sum_valid && sum_ready;
         if (ohs) begin
            chk($sformatf("sum_word[%0d]", oi), {16'd0, sum_word}, {16'd0, v.s[oi*W +: W]});
            chk($sformatf("sum_last[%0d]", oi), {31'd0, sum_last}, {31'd0, (oi == N-1)});
            if (oi == N-1) chk("cout", {31'd0, cout}, {31'd0, v.c});
            oi++;
         end
         if (ihs) ai++;
         cyc++;
         @(negedge clk);
      end
      if (cyc >= 200) chk("op_timeout", 32'd1, 32'd0);
      in_valid = 1'b0; start = 1'b0; sum_ready = 1'b1;
      #1;
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("sum_valid_after", {31'd0, sum_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk("done_single", {31'd0, done}, 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("cout_held", {31'd0, cout}, {31'd0, v.c});
      cycles = cyc;
   endtask

   vec_t tbl[6];
   int   cyc_used;
   int   ai;

   initial begin
      tbl[0] = mk({8{16'hFFFF}}, {112'h0, 16'h0001}, '0, 1'b1);
      tbl[1] = mk({8{16'h1234}}, {8{16'h1111}}, {8{16'h2345}}, 1'b0);
      tbl[2] = mk(128'h0007_0006_0005_0004_0003_0002_0001_0000, {8{16'h0010}},
                  128'h0017_0016_0015_0014_0013_0012_0011_0010, 1'b0);
      tbl[3] = mk({8{16'hFFFF}}, {8{16'hFFFF}}, {{7{16'hFFFF}}, 16'hFFFE}, 1'b1);
      tbl[4] = mk({16'h8000, 112'h0}, {16'h8000, 112'h0}, '0, 1'b1);
      tbl[5] = mk(128'h0000FFFF0000FFFF0000FFFF0000FFFF, 128'h1,
                  128'h0000FFFF0000FFFF0000FFFF00010000, 1'b0);

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; sum_ready = 1'b1;
      a_word = '0; b_word = '0;
`ifdef WIDE_ADD_SUB_EN
      sub = 1'b0;
`endif
      #1;
      chk("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
      chk("rst_sum_word", {16'd0, sum_word}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Operand words in IDLE must be refused.
      @(negedge clk);
      in_valid = 1'b1; a_word = 16'hAAAA; b_word = 16'h5555;
      #1 chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      #1;
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_sum_valid", {31'd0, sum_valid}, 32'd0);
      in_valid = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i], (i == 2) ? 3 : 0, (i == 3), 1'b0, cyc_used);
         chk($sformatf("cycles_vec%0d", i), cyc_used, (i == 2) ? 32'd12 : 32'd9);
      end

      // Abort after word 4 has been accepted.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ai = 0;
      for (int c = 0; c < 20 && ai < 5; c++) begin
         in_valid = 1'b1; a_word = 16'h1111; b_word = 16'h2222; sum_ready = 1'b1;
         #1;
         if (in_ready) ai++;
         @(negedge clk);
      end
      chk("abort_words_accepted", ai, 32'd5);
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("abort_sum_valid", {31'd0, sum_valid}, 32'd0);
      chk("abort_sum_word", {16'd0, sum_word}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
      chk("abort_sum_last", {31'd0, sum_last}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 1) rst = 1'b0;
         #1 chk("abort_no_done", {31'd0, done}, 32'd0);
      end
      run_op(tbl[1], 0, 1'b0, 1'b0, cyc_used);
      chk("post_abort_cycles", cyc_used, 32'd9);

`ifdef WIDE_ADD_SUB_EN
      run_op(mk('0, 128'h1, {8{16'hFFFF}}, 1'b0), 0, 1'b0, 1'b1, cyc_used);
      run_op(mk(128'h5, 128'h3, 128'h2, 1'b1), 0, 1'b0, 1'b1, cyc_used);
      run_op(tbl[1], 0, 1'b0, 1'b0, cyc_used);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Sequences one WORD_W-bit adder slice over NUM_WORDS operand words to form a NUM_WORDS*WORD_W-bit sum; default is 8 x 16 = 128-bit.
- Operands stream in least-significant word first, and sum words stream out in the same order.
- The registered carry is chained between words, so one narrow adder serves the wide add.
- Sits between the operand source, such as the wide-adder test harness or register file, and the result sink.

Parameters:
- WORD_W, 16, width of one operand/sum word and of the adder slice.
- NUM_WORDS, 8, words per operation; must be >= 2.
- CNT_W, $clog2(NUM_WORDS), width of the word counter (derived).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins an operation; sampled only in IDLE.
- in_valid  in  1  operand word pair is valid.
- in_ready  out  1  sequencer accepts an operand word this cycle.
- a_word  in  WORD_W  operand A word.
- b_word  in  WORD_W  operand B word.
- sum_word  out  WORD_W  registered sum word.
- sum_valid  out  1  sum_word is valid.
- sum_ready  in  1  sink accepts sum_word.
- sum_last  out  1  qualifies the final (most-significant) sum word.
- cout  out  1  carry out of the full-width add; valid while sum_last=1 and held until the next start.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse when the operation completes.

Behaviour:
- Reset (async, any state): state=IDLE; counter=0; carry_reg=0; sum_word=0; sum_valid=0; sum_last=0; cout=0; busy=0; done=0; in_ready=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start=1.
  - On entry: carry_reg=0, counter=0, cout cleared, busy=1.
  - Operand words presented in IDLE are not accepted (in_ready=0).
- RUN: in_ready = !sum_valid || sum_ready.
  - Input handshake is in_valid && in_ready.
  - On handshake: {c, s} = a_word + b_word + carry_reg, computed at WORD_W+1 bits.
  - The sum is registered into sum_word, c into carry_reg, and sum_valid is set. Latency is 1 cycle from input handshake to sum_valid.
  - counter increments on each handshake.
  - When the accepted word has counter == NUM_WORDS-1:
    - sum_last=1 and cout=c, both registered with that word.
    - State goes to DRAIN.
- Output handshake (sum_valid && sum_ready) with no new input handshake in the same cycle: sum_valid=0.
  - Simultaneous output and input handshakes keep sum_valid=1 with the new word, giving full throughput of one word per cycle.
- Holding: sum_word, sum_last and sum_valid hold stable while sum_valid && !sum_ready.
- DRAIN: in_ready=0. On the handshake of the last word: sum_valid=0, sum_last=0, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 on exit, state goes to IDLE. cout holds its value until the next start.
- start outside IDLE is ignored. in_valid outside RUN is ignored.
- Arithmetic is unsigned modulo 2^(NUM_WORDS*WORD_W); cout is the bit above that.
- Reset asserted mid-operation aborts immediately. Partial results are discarded and no done pulse is produced.

Optional Feature:
- Macro: WIDE_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled together with start and latched for the whole operation.
  - When sub=1, every word uses ~b_word, and carry_reg initialises to 1 at start, giving A-B.
  - cout=1 means no borrow.
- Undefined: no sub port; addition only; carry_reg initialises to 0.

Decomposition:
- Package wide_add_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE).
  - default WORD_W and NUM_WORDS localparams.
- Sub-module add_slice: combinational, parameter WORD_W, ports x, y, cin, s, cout. Instantiated once in the sequencer; it can later be swapped for a CLA slice without touching the FSM.

Test Plan:
- Ripple carry: start; word0 A=0xFFFF, B=0x0001; words1-7 A=0xFFFF, B=0x0000, sum_ready=1 throughout. Expect sum words all 0x0000, sum_last on word 7, cout=1, done one cycle after the last output handshake.
- Throughput: 8 back-to-back words with A=0x1234, B=0x1111. Expect each sum word 0x2345, 1-cycle latency, in_ready held high, no bubbles.
- Backpressure: hold sum_ready=0 for 3 cycles after word 2. Expect in_ready=0 and sum_word stable at the word-2 value; the operation then resumes with no loss or duplication.
- Ignored inputs: start pulsed during RUN, and in_valid pulsed in IDLE. Expect no state change, no accepted words, and result identical to an undisturbed run.
- Mid-operation reset: assert rst after word 4 is accepted. Expect all outputs 0 and state IDLE immediately with no done pulse; a fresh operation afterwards computes correctly.
- WIDE_ADD_SUB_EN, sub=1: A=0 and B=1 (word0 B=0x0001, others 0). Expect all sum words 0xFFFF and cout=0 (borrow).
